// File: rtl/pll_md_pkg.sv
// Shared constants for the PLL MD-port responder: opcode encodings, register
// map addresses and the bit positions inside the CTRL and STATUS registers.
package pll_md_pkg;

  // MD opcodes carried on mdopc
  localparam logic [1:0] MD_NOP  = 2'b00;
  localparam logic [1:0] MD_WR   = 2'b01;
  localparam logic [1:0] MD_RD   = 2'b10;
  localparam logic [1:0] MD_ADDR = 2'b11;

  // Register map
  localparam int unsigned REG_FBDIV    = 0;
  localparam int unsigned REG_IDIV     = 1;
  localparam int unsigned REG_ODIV0    = 2;  // ODIV0..ODIV3 occupy 2..5
  localparam int unsigned NUM_ODIV     = 4;
  localparam int unsigned REG_CTRL     = 6;
  localparam int unsigned REG_STATUS   = 7;
  localparam int unsigned REG_SCRATCH0 = 8;

  // CTRL / STATUS bit indices
  localparam int unsigned CTRL_APPLY_BIT  = 0;
  localparam int unsigned STATUS_LOCK_BIT = 0;
  localparam int unsigned STATUS_ACQ_BIT  = 1;

endpackage

// File: rtl/pll_lock_model.sv
// Behavioural PLL lock model: HOLD / ACQUIRE / LOCKED state machine with an
// acquisition counter. lock rises LOCK_CYCLES edges after acquisition starts.
//  mdclk     in  clock
//  reset     in  synchronous active-high reset (enters ACQUIRE, cnt=0)
//  pll_rst   in  holds the model in HOLD; dominates restart
//  restart   in  config apply; restarts ACQUIRE at cnt=0
//  lock      out registered lock indication
//  acquiring out registered "in ACQUIRE" indication
module pll_lock_model #(
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic mdclk,
  input  logic reset,
  input  logic pll_rst,
  input  logic restart,
  output logic lock,
  output logic acquiring
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  lock_state_e      state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      state     <= ST_ACQUIRE;
      cnt       <= '0;
      lock      <= 1'b0;
      acquiring <= 1'b1;
    end else if (pll_rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      lock      <= 1'b0;
      acquiring <= 1'b0;
    end else if (restart) begin
      state     <= ST_ACQUIRE;
      cnt       <= '0;
      lock      <= 1'b0;
      acquiring <= 1'b1;
    end else begin
      unique case (state)
        ST_HOLD: begin
          state     <= ST_ACQUIRE;
          cnt       <= '0;
          acquiring <= 1'b1;
        end
        ST_ACQUIRE: begin
          if (cnt == CNT_LAST) begin
            state     <= ST_LOCKED;
            lock      <= 1'b1;
            acquiring <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          lock      <= 1'b1;
          acquiring <= 1'b0;
        end
        default: begin
          state     <= ST_HOLD;
          cnt       <= '0;
          lock      <= 1'b0;
          acquiring <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pll_md_responder.sv
// Responder end of the PLL MD reconfiguration port. Decodes mdopc/mdainc/mdwdi,
// keeps a shadow divider register file plus an active copy, returns registered
// read data on mdrdo and models lock through pll_lock_model.
//  mdclk      in   clock
//  reset      in   synchronous active-high reset
//  pll_rst    in   PLL reset, holds lock low
//  mdopc      in   2  opcode (NOP/WRITE/READ/ADDR-LOAD)
//  mdainc     in   1  post-increment address on WRITE/READ
//  mdwdi      in   8  write data or load address
//  mdrdo      out  8  read data, one cycle after READ, held between READs
//  lock       out  1  modelled lock
//  cfg_fbdiv  out  8  active feedback divider
//  cfg_idiv   out  8  active input divider
//  cfg_odiv   out  32 active output dividers, byte k = clkout k
//  cfg_apply  out  1  one-cycle pulse when shadow is copied to active
module pll_md_responder
  import pll_md_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter logic [7:0]  DEF_FBDIV   = 8'd16,
  parameter logic [7:0]  DEF_IDIV    = 8'd1,
  parameter logic [7:0]  DEF_ODIV    = 8'd8
) (
  input  logic        mdclk,
  input  logic        reset,
  input  logic        pll_rst,
  input  logic [1:0]  mdopc,
  input  logic        mdainc,
  input  logic [7:0]  mdwdi,
  output logic [7:0]  mdrdo,
  output logic        lock,
  output logic        cfg_apply,
  output logic [7:0]  cfg_fbdiv,
  output logic [7:0]  cfg_idiv,
  output logic [31:0] cfg_odiv
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [7:0]        regs [NUM_REGS];   // shadow dividers + scratch
  logic [7:0]        act_odiv [NUM_ODIV];
  logic [7:0]        rd_data;
  logic              acquiring;
  logic              in_range;
  logic              is_wr;
  logic              is_rd;
  logic              wr_en;
  logic              apply_hit;

  assign is_wr    = (mdopc == MD_WR);
  assign is_rd    = (mdopc == MD_RD);
  assign in_range = (32'(addr) < NUM_REGS);
  assign wr_en    = is_wr && in_range &&
                    (addr != ADDR_W'(REG_CTRL)) && (addr != ADDR_W'(REG_STATUS));
  assign apply_hit = is_wr && (addr == ADDR_W'(REG_CTRL)) && mdwdi[CTRL_APPLY_BIT];

  // Out-of-range pointers (non-pow2 depth) wrap to 0 like the top address.
  assign addr_inc = (32'(addr) >= NUM_REGS - 1) ? '0 : addr + ADDR_W'(1);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = 8'h00;
    if (addr == ADDR_W'(REG_STATUS)) begin
      rd_data[STATUS_LOCK_BIT] = lock;
      rd_data[STATUS_ACQ_BIT]  = acquiring;
    end else if (in_range && addr != ADDR_W'(REG_CTRL)) begin
      rd_data = regs[addr];
    end
  end

  // NOTE: the register file is an explicit reset target here (scratch regs
  // must read 0 after reset), so it is built from flops, not an inferred RAM.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      addr  <= '0;
      mdrdo <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      regs[REG_FBDIV] <= DEF_FBDIV;
      regs[REG_IDIV]  <= DEF_IDIV;
      for (int k = 0; k < NUM_ODIV; k++) regs[REG_ODIV0 + k] <= DEF_ODIV;
    end else begin
      if (mdopc == MD_ADDR) begin
        addr <= mdwdi[ADDR_W-1:0];
      end else if ((is_wr || is_rd) && mdainc) begin
        addr <= addr_inc;
      end
      if (wr_en) regs[addr] <= mdwdi;
      if (is_rd) mdrdo <= rd_data;
    end
  end

  // Active copy; a write to CTRL never touches the shadow, so copying the
  // shadow on the same edge as the CTRL write sees final shadow values.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      cfg_apply <= 1'b0;
      cfg_fbdiv <= DEF_FBDIV;
      cfg_idiv  <= DEF_IDIV;
      for (int k = 0; k < NUM_ODIV; k++) act_odiv[k] <= DEF_ODIV;
    end else begin
      cfg_apply <= apply_hit;
      if (apply_hit) begin
        cfg_fbdiv <= regs[REG_FBDIV];
        cfg_idiv  <= regs[REG_IDIV];
        for (int k = 0; k < NUM_ODIV; k++) act_odiv[k] <= regs[REG_ODIV0 + k];
      end
    end
  end

  assign cfg_odiv = {act_odiv[3], act_odiv[2], act_odiv[1], act_odiv[0]};

  pll_lock_model #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock (
    .mdclk     (mdclk),
    .reset     (reset),
    .pll_rst   (pll_rst),
    .restart   (apply_hit),
    .lock      (lock),
    .acquiring (acquiring)
  );

endmodule

// File: tb/tb_pll_md_responder.sv
// Directed testbench for pll_md_responder: reset/lock timing, shadow writes
// and reads, apply, address wrap, pll_rst with same-cycle apply, and reset
// during activity.
module tb_pll_md_responder;
  import pll_md_pkg::*;

  logic        mdclk = 1'b0;
  logic        reset = 1'b1;
  logic        pll_rst = 1'b0;
  logic [1:0]  mdopc = MD_NOP;
  logic        mdainc = 1'b0;
  logic [7:0]  mdwdi = 8'h00;
  logic [7:0]  mdrdo;
  logic        lock;
  logic        cfg_apply;
  logic [7:0]  cfg_fbdiv;
  logic [7:0]  cfg_idiv;
  logic [31:0] cfg_odiv;

  int errors = 0;
  int checks = 0;

  pll_md_responder dut (
    .mdclk     (mdclk),
    .reset     (reset),
    .pll_rst   (pll_rst),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo),
    .lock      (lock),
    .cfg_apply (cfg_apply),
    .cfg_fbdiv (cfg_fbdiv),
    .cfg_idiv  (cfg_idiv),
    .cfg_odiv  (cfg_odiv)
  );

  always #5 mdclk = ~mdclk;

  // Drive one MD cycle and return 1 time unit after the sampling edge.
  task automatic cyc(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi);
    mdopc  = opc;
    mdainc = ainc;
    mdwdi  = wdi;
    @(posedge mdclk);
    #1;
  endtask

  task automatic test_reset;
    logic exp_lock;
    reset = 1'b1;
    cyc(MD_NOP, 1'b0, 8'h00);
    reset = 1'b0;
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b want 0", lock); end
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL rst_mdrdo: got %h want 00", mdrdo); end
    checks++; if (cfg_apply !== 1'b0) begin errors++; $display("FAIL rst_apply: got %b want 0", cfg_apply); end
    checks++; if (cfg_fbdiv !== 8'd16) begin errors++; $display("FAIL rst_fbdiv: got %h want 10", cfg_fbdiv); end
    checks++; if (cfg_idiv !== 8'd1) begin errors++; $display("FAIL rst_idiv: got %h want 01", cfg_idiv); end
    checks++; if (cfg_odiv !== 32'h0808_0808) begin errors++; $display("FAIL rst_odiv: got %h want 08080808", cfg_odiv); end
    for (int i = 1; i <= 64; i++) begin
      cyc(MD_NOP, 1'b0, 8'h00);
      exp_lock = (i == 64);
      checks++;
      if (lock !== exp_lock) begin errors++; $display("FAIL rst_lock_timing cycle %0d: got %b want %b", i, lock, exp_lock); end
    end
  endtask

  task automatic test_shadow_rw;
    cyc(MD_ADDR, 1'b0, 8'h00);
    cyc(MD_WR,   1'b1, 8'h20);
    cyc(MD_WR,   1'b1, 8'h02);
    cyc(MD_ADDR, 1'b0, 8'h00);
    cyc(MD_RD,   1'b1, 8'h00);
    checks++; if (mdrdo !== 8'h20) begin errors++; $display("FAIL rw_rd0: got %h want 20", mdrdo); end
    cyc(MD_RD,   1'b1, 8'h00);
    checks++; if (mdrdo !== 8'h02) begin errors++; $display("FAIL rw_rd1: got %h want 02", mdrdo); end
    cyc(MD_NOP,  1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h02) begin errors++; $display("FAIL rw_hold: got %h want 02", mdrdo); end
    checks++; if (cfg_fbdiv !== 8'd16) begin errors++; $display("FAIL rw_fbdiv_active: got %h want 10", cfg_fbdiv); end
    checks++; if (cfg_idiv !== 8'd1) begin errors++; $display("FAIL rw_idiv_active: got %h want 01", cfg_idiv); end
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL rw_lock: got %b want 1", lock); end
  endtask

  task automatic test_apply;
    logic exp_lock;
    cyc(MD_ADDR, 1'b0, 8'h06);
    cyc(MD_WR,   1'b0, 8'h01);
    checks++; if (cfg_apply !== 1'b1) begin errors++; $display("FAIL ap_pulse: got %b want 1", cfg_apply); end
    checks++; if (cfg_fbdiv !== 8'h20) begin errors++; $display("FAIL ap_fbdiv: got %h want 20", cfg_fbdiv); end
    checks++; if (cfg_idiv !== 8'h02) begin errors++; $display("FAIL ap_idiv: got %h want 02", cfg_idiv); end
    checks++; if (cfg_odiv !== 32'h0808_0808) begin errors++; $display("FAIL ap_odiv: got %h want 08080808", cfg_odiv); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL ap_lock_fall: got %b want 0", lock); end
    for (int i = 1; i <= 64; i++) begin
      cyc(MD_NOP, 1'b0, 8'h00);
      if (i == 1) begin
        checks++; if (cfg_apply !== 1'b0) begin errors++; $display("FAIL ap_pulse_end: got %b want 0", cfg_apply); end
      end
      exp_lock = (i == 64);
      checks++;
      if (lock !== exp_lock) begin errors++; $display("FAIL ap_relock cycle %0d: got %b want %b", i, lock, exp_lock); end
    end
  endtask

  task automatic test_addr_wrap;
    cyc(MD_ADDR, 1'b0, 8'h0F);
    cyc(MD_WR,   1'b1, 8'hA5);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h20) begin errors++; $display("FAIL wrap_rd0: got %h want 20", mdrdo); end
    cyc(MD_ADDR, 1'b0, 8'h0F);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'hA5) begin errors++; $display("FAIL wrap_rd15: got %h want a5", mdrdo); end
    // mdainc has no effect with ADDR-LOAD or NOP
    cyc(MD_ADDR, 1'b1, 8'h03);
    cyc(MD_NOP,  1'b1, 8'h00);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h08) begin errors++; $display("FAIL ainc_ignored: got %h want 08", mdrdo); end
    // STATUS is read-only; CTRL reads back 0
    cyc(MD_ADDR, 1'b0, 8'h07);
    cyc(MD_WR,   1'b0, 8'hFF);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h01) begin errors++; $display("FAIL status_ro: got %h want 01", mdrdo); end
    cyc(MD_ADDR, 1'b0, 8'h06);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL ctrl_rd0: got %h want 00", mdrdo); end
  endtask

  task automatic test_pll_rst_apply;
    logic lock_bad;
    lock_bad = 1'b0;
    cyc(MD_ADDR, 1'b0, 8'h06);   // still locked here
    cyc(MD_WR,   1'b0, 8'h01);   // apply: ACQUIRE, cnt=0
    lock_bad |= (lock !== 1'b0);
    cyc(MD_ADDR, 1'b0, 8'h00);
    lock_bad |= (lock !== 1'b0);
    cyc(MD_WR,   1'b0, 8'h30);
    lock_bad |= (lock !== 1'b0);
    cyc(MD_ADDR, 1'b0, 8'h06);
    lock_bad |= (lock !== 1'b0);
    for (int i = 4; i <= 30; i++) begin
      cyc(MD_NOP, 1'b0, 8'h00);
      lock_bad |= (lock !== 1'b0);
    end
    // cnt is now 30: pll_rst together with an apply
    pll_rst = 1'b1;
    cyc(MD_WR, 1'b0, 8'h01);
    lock_bad |= (lock !== 1'b0);
    checks++; if (cfg_apply !== 1'b1) begin errors++; $display("FAIL prst_apply_pulse: got %b want 1", cfg_apply); end
    checks++; if (cfg_fbdiv !== 8'h30) begin errors++; $display("FAIL prst_apply_fbdiv: got %h want 30", cfg_fbdiv); end
    cyc(MD_ADDR, 1'b0, 8'h07);
    lock_bad |= (lock !== 1'b0);
    cyc(MD_RD,   1'b0, 8'h00);
    lock_bad |= (lock !== 1'b0);
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL prst_status_hold: got %h want 00", mdrdo); end
    cyc(MD_NOP,  1'b0, 8'h00);
    lock_bad |= (lock !== 1'b0);
    pll_rst = 1'b0;
    cyc(MD_RD, 1'b0, 8'h00);     // first edge with pll_rst low: reads pre-edge HOLD
    lock_bad |= (lock !== 1'b0);
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL prst_status_edge: got %h want 00", mdrdo); end
    cyc(MD_RD, 1'b0, 8'h00);
    lock_bad |= (lock !== 1'b0);
    checks++; if (mdrdo !== 8'h02) begin errors++; $display("FAIL prst_status_acq: got %h want 02", mdrdo); end
    for (int i = 2; i <= 63; i++) begin
      cyc(MD_NOP, 1'b0, 8'h00);
      lock_bad |= (lock !== 1'b0);
    end
    checks++; if (lock_bad !== 1'b0) begin errors++; $display("FAIL prst_lock_low: got early lock=%b want 0", lock_bad); end
    cyc(MD_RD, 1'b0, 8'h00);     // lock rises on this edge; STATUS shows pre-edge
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL prst_relock: got %b want 1", lock); end
    checks++; if (mdrdo !== 8'h02) begin errors++; $display("FAIL prst_status_pre: got %h want 02", mdrdo); end
    cyc(MD_RD, 1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h01) begin errors++; $display("FAIL prst_status_lock: got %h want 01", mdrdo); end
  endtask

  task automatic test_mid_reset;
    cyc(MD_ADDR, 1'b0, 8'h09);
    cyc(MD_WR,   1'b0, 8'h5A);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h5A) begin errors++; $display("FAIL mr_scratch_wr: got %h want 5a", mdrdo); end
    reset = 1'b1;
    cyc(MD_RD, 1'b0, 8'h00);
    reset = 1'b0;
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL mr_mdrdo: got %h want 00", mdrdo); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL mr_lock: got %b want 0", lock); end
    checks++; if (cfg_apply !== 1'b0) begin errors++; $display("FAIL mr_apply: got %b want 0", cfg_apply); end
    checks++; if (cfg_fbdiv !== 8'd16) begin errors++; $display("FAIL mr_fbdiv: got %h want 10", cfg_fbdiv); end
    checks++; if (cfg_idiv !== 8'd1) begin errors++; $display("FAIL mr_idiv: got %h want 01", cfg_idiv); end
    checks++; if (cfg_odiv !== 32'h0808_0808) begin errors++; $display("FAIL mr_odiv: got %h want 08080808", cfg_odiv); end
    cyc(MD_RD, 1'b0, 8'h00);     // address pointer back at 0, shadow at default
    checks++; if (mdrdo !== 8'h10) begin errors++; $display("FAIL mr_shadow0: got %h want 10", mdrdo); end
    cyc(MD_ADDR, 1'b0, 8'h09);
    cyc(MD_RD,   1'b0, 8'h00);
    checks++; if (mdrdo !== 8'h00) begin errors++; $display("FAIL mr_scratch9: got %h want 00", mdrdo); end
  endtask

  initial begin
    test_reset();
    test_shadow_rw();
    test_apply();
    test_addr_wrap();
    test_pll_rst_apply();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
